// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle instruction fetch FSM with PC update and retire counter
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   imem_req/addr/ack/rdata - instruction memory read handshake (addr is always pc)
//   stall, branch, zero, jump - execute-stage controls, sampled only in EXEC
//   instr, instr_valid    - registered instruction word and its valid flag
//   op, funct             - opcode and function fields sliced from instr
//   pc, pc_plus4          - current instruction address and its sequential successor
//   retired               - count of completed instructions
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
    state_t state, state_next;
    // PC arithmetic is done on word addresses so bits [1:0] are zero by construction
    logic [29:0] br_word, pc_word_next;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign op        = instr[31:26];
    assign funct     = instr[5:0];
    assign br_word   = pc_plus4[31:2] + {{14{instr[15]}}, instr[15:0]};
    assign pc_word_next = jump ? {pc_plus4[31:28], instr[25:0]}
                        : (branch & zero) ? br_word : pc_plus4[31:2];
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: begin
                imem_req   = 1'b1;
                state_next = imem_ack ? EXEC : FETCH;
            end
            EXEC:  begin
                instr_valid = 1'b1;
                state_next  = stall ? EXEC : FETCH;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= {RESET_PC[31:2], 2'b00};
            instr   <= 32'd0;
            retired <= 32'd0;
        end else begin
            state <= state_next;
            if (state == FETCH && imem_ack)
                instr <= imem_rdata;
            if (state == EXEC && !stall) begin
                pc      <= {pc_word_next, 2'b00};
                retired <= retired + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of instr_fetch_unit against a PC/retire model
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0;
    logic        stall = 1'b0, branch = 1'b0, zero = 1'b0, jump = 1'b0;
    logic [31:0] instr, pc, pc_plus4, retired;
    logic        instr_valid;
    logic [5:0]  op, funct;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .branch(branch),
        .zero(zero), .jump(jump), .instr(instr), .instr_valid(instr_valid), .op(op),
        .funct(funct), .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [31:0] exp_pc = 32'd0, exp_ret = 32'd0;
    logic        o_timeout, o_stable, o_held, o_exec_valid;
    logic [31:0] o_fetch_addr, o_exec_instr, o_exec_pc, o_exec_pc4, o_exec_ret, o_next_addr, o_retired;
    logic [5:0]  o_op, o_funct;

    // Architectural next-PC rule, expressed on byte addresses
    function automatic logic [31:0] model_next(logic [31:0] cur, logic [31:0] ins, logic b, logic z, logic j);
        logic [31:0] seq;
        logic signed [15:0] imm;
        int off;
        seq = cur + 32'd4;
        imm = ins[15:0];
        off = imm;
        if (j) return (seq & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
        if (b && z) return seq + 32'(off * 4);
        return seq;
    endfunction

    // Runs one instruction through FETCH (dly wait states) and EXEC (nst stall cycles), recording observations
    task automatic do_instr(input logic [31:0] rd, input int dly, input int nst,
                            input logic b, input logic z, input logic j, input logic junk_ack);
        int n;
        o_timeout = 1'b0; o_stable = 1'b1; o_held = 1'b1; n = 0;
        while (imem_req !== 1'b1 && n < 4) begin @(negedge clk); n++; end
        if (imem_req !== 1'b1) begin o_timeout = 1'b1; return; end
        o_fetch_addr = imem_addr;
        for (int i = 0; i < dly; i++) begin
            imem_ack = 1'b0; stall = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom); jump = 1'($urandom);
            @(negedge clk);
            if (imem_req !== 1'b1 || imem_addr !== o_fetch_addr || instr_valid !== 1'b0) o_stable = 1'b0;
        end
        imem_ack = 1'b1; imem_rdata = rd;
        @(negedge clk);
        imem_ack = 1'b0;
        o_exec_valid = instr_valid; o_exec_instr = instr; o_exec_pc = pc; o_exec_pc4 = pc_plus4;
        o_op = op; o_funct = funct; o_exec_ret = retired;
        for (int i = 0; i < nst; i++) begin
            stall = 1'b1; branch = 1'($urandom); zero = 1'($urandom); jump = 1'($urandom);
            imem_ack = junk_ack; imem_rdata = $urandom;
            @(negedge clk);
            if (instr_valid !== 1'b1 || pc !== o_exec_pc || instr !== o_exec_instr || retired !== o_exec_ret) o_held = 1'b0;
        end
        imem_ack = 1'b0; stall = 1'b0; branch = b; zero = z; jump = j;
        @(negedge clk);
        branch = 1'b0; zero = 1'b0; jump = 1'b0;
        o_next_addr = imem_addr; o_retired = retired;
        exp_ret = exp_ret + 32'd1;
        exp_pc  = model_next(exp_pc, rd, b, z, j);
    endtask

    task automatic test_reset;
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc got=%h exp=00000000", pc); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        checks++; if (instr !== 32'd0) begin errors++; $display("FAIL reset_instr got=%h exp=00000000", instr); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL idle_to_fetch got=%b exp=1", imem_req); end
        checks++; if (instr !== 32'd0) begin errors++; $display("FAIL idle_ack_ignored got=%h exp=00000000", instr); end
        imem_ack = 1'b0;
        exp_pc = 32'd0; exp_ret = 32'd0;
    endtask

    task automatic test_sequential;
        do_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL seq_timeout got=%b exp=0", o_timeout); end
        checks++; if (o_fetch_addr !== 32'd0) begin errors++; $display("FAIL seq_fetch_addr got=%h exp=00000000", o_fetch_addr); end
        checks++; if (o_exec_valid !== 1'b1) begin errors++; $display("FAIL seq_latency_valid got=%b exp=1", o_exec_valid); end
        checks++; if (o_op !== 6'd0) begin errors++; $display("FAIL seq_op got=%h exp=00", o_op); end
        checks++; if (o_next_addr !== 32'h4) begin errors++; $display("FAIL seq_next got=%h exp=00000004", o_next_addr); end
        checks++; if (o_retired !== 32'd1) begin errors++; $display("FAIL seq_retired got=%0d exp=1", o_retired); end
    endtask

    task automatic test_branch;
        do_instr(32'h0800_0004, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (o_next_addr !== 32'h10) begin errors++; $display("FAIL br_setup got=%h exp=00000010", o_next_addr); end
        do_instr(32'h1000_FFFF, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (o_fetch_addr !== 32'h10) begin errors++; $display("FAIL br_fetch got=%h exp=00000010", o_fetch_addr); end
        checks++; if (o_next_addr !== 32'h10) begin errors++; $display("FAIL br_taken got=%h exp=00000010", o_next_addr); end
        do_instr(32'h1000_FFFF, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (o_next_addr !== 32'h14) begin errors++; $display("FAIL br_not_taken got=%h exp=00000014", o_next_addr); end
    endtask

    task automatic test_jump;
        do_instr(32'h0800_0008, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (o_next_addr !== 32'h20) begin errors++; $display("FAIL jmp_setup got=%h exp=00000020", o_next_addr); end
        do_instr(32'h0800_0040, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (o_op !== 6'h02) begin errors++; $display("FAIL jmp_op got=%h exp=02", o_op); end
        checks++; if (o_next_addr !== 32'h100) begin errors++; $display("FAIL jmp_priority got=%h exp=00000100", o_next_addr); end
    endtask

    task automatic test_wait_stall;
        do_instr(32'h0043_0820, 3, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (o_fetch_addr !== 32'h100) begin errors++; $display("FAIL ws_fetch got=%h exp=00000100", o_fetch_addr); end
        checks++; if (o_stable !== 1'b1) begin errors++; $display("FAIL ws_addr_stable got=%b exp=1", o_stable); end
        checks++; if (o_held !== 1'b1) begin errors++; $display("FAIL ws_stall_hold got=%b exp=1", o_held); end
        checks++; if (o_exec_instr !== 32'h0043_0820) begin errors++; $display("FAIL ws_instr got=%h exp=00430820", o_exec_instr); end
        checks++; if (o_next_addr !== 32'h104) begin errors++; $display("FAIL ws_next got=%h exp=00000104", o_next_addr); end
        checks++; if (o_retired !== exp_ret) begin errors++; $display("FAIL ws_retired got=%0d exp=%0d", o_retired, exp_ret); end
    endtask

    task automatic test_wrap;
        do_instr(32'h0800_0000, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (o_next_addr !== 32'h0) begin errors++; $display("FAIL wrap_setup0 got=%h exp=00000000", o_next_addr); end
        do_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (o_next_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_back_branch got=%h exp=fffffffc", o_next_addr); end
        do_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (o_exec_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4 got=%h exp=00000000", o_exec_pc4); end
        checks++; if (o_funct !== 6'h20) begin errors++; $display("FAIL wrap_funct got=%h exp=20", o_funct); end
        checks++; if (o_next_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got=%h exp=00000000", o_next_addr); end
    endtask

    task automatic test_reset_mid_fetch;
        imem_ack = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_in_fetch got=%b exp=1", imem_req); end
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req got=%b exp=0", imem_req); end
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL mid_pc got=%h exp=00000000", pc); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL mid_retired got=%0d exp=0", retired); end
        checks++; if (instr !== 32'd0) begin errors++; $display("FAIL mid_instr got=%h exp=00000000", instr); end
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || instr !== 32'd0) begin errors++; $display("FAIL mid_ack_ignored got=req%b/%h exp=req1/00000000", imem_req, instr); end
        exp_pc = 32'd0; exp_ret = 32'd0;
    endtask

    task automatic test_random;
        logic [31:0] rd;
        logic b, z, j;
        for (int k = 0; k < 150; k++) begin
            rd = $urandom; b = ($urandom % 3) == 0; z = 1'($urandom); j = ($urandom % 4) == 0;
            checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL rnd_fetch[%0d] got=%h exp=%h", k, imem_addr, exp_pc); end
            do_instr(rd, $urandom_range(0, 3), $urandom_range(0, 2), b, z, j, 1'($urandom));
            checks++; if (o_timeout !== 1'b0 || o_stable !== 1'b1 || o_held !== 1'b1) begin errors++; $display("FAIL rnd_protocol[%0d] got=t%b s%b h%b exp=t0 s1 h1", k, o_timeout, o_stable, o_held); end
            checks++; if (o_exec_instr !== rd || o_op !== rd[31:26] || o_funct !== rd[5:0]) begin errors++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", k, o_exec_instr, rd); end
            checks++; if (o_exec_pc4 !== o_fetch_addr + 32'd4) begin errors++; $display("FAIL rnd_pc_plus4[%0d] got=%h exp=%h", k, o_exec_pc4, o_fetch_addr + 32'd4); end
            checks++; if (o_next_addr !== exp_pc) begin errors++; $display("FAIL rnd_next[%0d] got=%h exp=%h", k, o_next_addr, exp_pc); end
            checks++; if (o_retired !== exp_ret) begin errors++; $display("FAIL rnd_retired[%0d] got=%0d exp=%0d", k, o_retired, exp_ret); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wait_stall();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
